// File: rtl/change_dispenser.sv
// Change dispenser: turns one change amount into greedy largest-coin-first
// eject requests to a coin hopper, skipping empty and jammed denominations.
module change_dispenser #(
  parameter int CURRENCY_WIDTH  = 7,
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int DENOM0          = 25,
  parameter int DENOM1          = 10,
  parameter int DENOM2          = 5,
  parameter int DENOM3          = 1,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       dispense_valid,
  input  logic [ITEM_ADDR_WIDTH-1:0] item_dispensed,
  input  logic [CURRENCY_WIDTH-1:0]  currency_change,
  input  logic [3:0]                 coin_empty,
  input  logic                       coin_ready,
  output logic                       coin_valid,
  output logic [1:0]                 coin_sel,
  output logic                       busy,
  output logic                       chg_done,
  output logic [ITEM_ADDR_WIDTH-1:0] chg_item,
  output logic [CURRENCY_WIDTH-1:0]  chg_short,
  output logic [7:0]                 coin_count,
  output logic                       req_drop
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CURRENCY_WIDTH-1:0] DENOM [4] = '{
    CURRENCY_WIDTH'(DENOM0), CURRENCY_WIDTH'(DENOM1),
    CURRENCY_WIDTH'(DENOM2), CURRENCY_WIDTH'(DENOM3)
  };

  state_t                     state, state_n;
  logic [CURRENCY_WIDTH-1:0]  remaining, remaining_n;
  logic [ITEM_ADDR_WIDTH-1:0] tag, tag_n;
  logic [3:0]                 jam, jam_n;
  logic [7:0]                 count, count_n;
  logic [TW-1:0]              tcnt, tcnt_n;
  logic                       coin_valid_n, busy_n, chg_done_n, req_drop_n;
  logic [1:0]                 coin_sel_n;
  logic [ITEM_ADDR_WIDTH-1:0] chg_item_n;
  logic [CURRENCY_WIDTH-1:0]  chg_short_n;
  logic [7:0]                 coin_count_n;
  logic                       found;
  logic [1:0]                 pick;

  // Greedy candidate: lowest index that fits, is stocked and is not jammed.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (DENOM[i] <= remaining && !coin_empty[i] && !jam[i]) begin
        found = 1'b1;
        pick  = 2'(i);
      end else begin
        found = found;
      end
    end
  end

  // Next-state and next-register values for the whole transaction.
  always_comb begin
    state_n      = state;
    remaining_n  = remaining;
    tag_n        = tag;
    jam_n        = jam;
    count_n      = count;
    tcnt_n       = tcnt;
    coin_valid_n = coin_valid;
    coin_sel_n   = coin_sel;
    chg_done_n   = 1'b0;
    chg_item_n   = chg_item;
    chg_short_n  = chg_short;
    coin_count_n = coin_count;
    req_drop_n   = dispense_valid && (state != IDLE);
    case (state)
      IDLE: begin
        if (dispense_valid) begin
          remaining_n = currency_change;
          tag_n       = item_dispensed;
          jam_n       = 4'd0;
          count_n     = 8'd0;
          state_n     = (currency_change == '0) ? DONE : SELECT;
        end else begin
          state_n = IDLE;
        end
      end
      SELECT: begin
        if (remaining == '0 || !found) begin
          state_n = DONE;
        end else begin
          coin_sel_n   = pick;
          coin_valid_n = 1'b1;
          tcnt_n       = '0;
          state_n      = ISSUE;
        end
      end
      ISSUE: begin
        if (coin_ready) begin
          remaining_n  = remaining - DENOM[coin_sel];
          count_n      = (count == 8'hFF) ? count : count + 8'd1;
          coin_valid_n = 1'b0;
          state_n      = SELECT;
        end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          // Hopper never took this coin: stop trying this denomination.
          jam_n[coin_sel] = 1'b1;
          coin_valid_n    = 1'b0;
          state_n         = SELECT;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
      end
      DONE: begin
        chg_done_n   = 1'b1;
        chg_short_n  = remaining;
        coin_count_n = count;
        chg_item_n   = tag;
        state_n      = IDLE;
      end
      default: begin
        state_n      = IDLE;
        coin_valid_n = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      remaining  <= '0;
      tag        <= '0;
      jam        <= 4'd0;
      count      <= 8'd0;
      tcnt       <= '0;
      coin_valid <= 1'b0;
      coin_sel   <= 2'd0;
      busy       <= 1'b0;
      chg_done   <= 1'b0;
      chg_item   <= '0;
      chg_short  <= '0;
      coin_count <= 8'd0;
      req_drop   <= 1'b0;
    end else begin
      state      <= state_n;
      remaining  <= remaining_n;
      tag        <= tag_n;
      jam        <= jam_n;
      count      <= count_n;
      tcnt       <= tcnt_n;
      coin_valid <= coin_valid_n;
      coin_sel   <= coin_sel_n;
      busy       <= busy_n;
      chg_done   <= chg_done_n;
      chg_item   <= chg_item_n;
      chg_short  <= chg_short_n;
      coin_count <= coin_count_n;
      req_drop   <= req_drop_n;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed vector table, hand-written
// corner sequences and randomized transactions against a greedy payout model.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       dispense_valid = 1'b0;
  logic [9:0] item_dispensed = 10'd0;
  logic [6:0] currency_change = 7'd0;
  logic [3:0] coin_empty = 4'd0;
  logic       coin_ready = 1'b0;
  logic       coin_valid, busy, chg_done, req_drop;
  logic [1:0] coin_sel;
  logic [9:0] chg_item;
  logic [6:0] chg_short;
  logic [7:0] coin_count;

  change_dispenser dut (
    .clk(clk), .rstn(rstn), .dispense_valid(dispense_valid),
    .item_dispensed(item_dispensed), .currency_change(currency_change),
    .coin_empty(coin_empty), .coin_ready(coin_ready), .coin_valid(coin_valid),
    .coin_sel(coin_sel), .busy(busy), .chg_done(chg_done), .chg_item(chg_item),
    .chg_short(chg_short), .coin_count(coin_count), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int sel_log [0:8191];
  int xfer_n = 0;
  int done_cnt = 0;
  int exp_q [$];
  int denoms [4] = '{25, 10, 5, 1};

  // Transfer log: every accepted coin in order, plus completion pulses.
  always @(posedge clk) begin
    if (coin_valid && coin_ready && xfer_n < 8192) begin
      sel_log[xfer_n] <= int'(coin_sel);
      xfer_n <= xfer_n + 1;
    end
    if (chg_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Greedy payout from the stocked coins, largest first.
  task automatic model(input int amt, input logic [3:0] empty, output int short_m, output int cnt_m);
    int rem;
    rem = amt;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (!empty[i]) begin
        while (rem >= denoms[i]) begin
          rem -= denoms[i];
          exp_q.push_back(i);
        end
      end
    end
    short_m = rem;
    cnt_m = exp_q.size();
  endtask

  task automatic seq_chk(input string name, input int first_x);
    int ok;
    ok = 1;
    if (xfer_n - first_x != exp_q.size()) ok = 0;
    else for (int k = 0; k < exp_q.size(); k++) if (sel_log[first_x + k] != exp_q[k]) ok = 0;
    chk(name, ok, 1);
  endtask

  task automatic set_ready(input int mode, inout int stall);
    case (mode)
      0: coin_ready = 1'b1;
      1: begin
        coin_ready = ($urandom_range(0, 3) != 0) || (stall >= 3);
        stall = coin_ready ? 0 : stall + 1;
      end
      2: coin_ready = (coin_sel != 2'd0);
      default: coin_ready = 1'b1;
    endcase
  endtask

  // One transaction; lat = edges after accept when chg_done was seen.
  task automatic run_txn(input logic [6:0] amt, input logic [3:0] empty, input logic [9:0] tag,
                         input int mode, output int lat, output int cv_lat, output int hi0,
                         output int first_x);
    int stall;
    stall = 0;
    cv_lat = 0;
    hi0 = 0;
    @(negedge clk);
    first_x = xfer_n;
    dispense_valid = 1'b1;
    currency_change = amt;
    item_dispensed = tag;
    coin_empty = empty;
    set_ready(mode, stall);
    @(negedge clk);
    dispense_valid = 1'b0;
    lat = 1;
    while (1) begin
      if (coin_valid && cv_lat == 0) cv_lat = lat;
      if (coin_valid && coin_sel == 2'd0) hi0++;
      if (chg_done || lat >= 1500) break;
      set_ready(mode, stall);
      @(negedge clk);
      lat++;
    end
    if (!chg_done) chk("txn_timeout", 0, 1);
  endtask

  typedef struct {
    logic [6:0] amount;
    logic [3:0] empty;
    int         short_e;
    int         count_e;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, cv_lat, hi0, fx, sm, cm, d0, n;
    vecs[0] = '{7'd68,  4'b0000, 0, 7};
    vecs[1] = '{7'd30,  4'b0010, 0, 2};
    vecs[2] = '{7'd0,   4'b0000, 0, 0};
    vecs[3] = '{7'd3,   4'b1000, 3, 0};
    vecs[4] = '{7'd99,  4'b0000, 0, 9};
    vecs[5] = '{7'd127, 4'b0001, 0, 15};
    vecs[6] = '{7'd7,   4'b1100, 7, 0};
    vecs[7] = '{7'd19,  4'b0100, 0, 10};

    repeat (3) @(negedge clk);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_chg_done", int'(chg_done), 0);
    chk("rst_chg_short", int'(chg_short), 0);
    chk("rst_coin_count", int'(coin_count), 0);
    chk("rst_chg_item", int'(chg_item), 0);
    chk("rst_req_drop", int'(req_drop), 0);
    rstn = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_txn(vecs[v].amount, vecs[v].empty, 10'(v + 100), 0, lat, cv_lat, hi0, fx);
      chk($sformatf("v%0d_short", v), int'(chg_short), vecs[v].short_e);
      chk($sformatf("v%0d_count", v), int'(coin_count), vecs[v].count_e);
      chk($sformatf("v%0d_item", v), int'(chg_item), v + 100);
      chk($sformatf("v%0d_xfers", v), xfer_n - fx, vecs[v].count_e);
      if (vecs[v].count_e == 0) chk($sformatf("v%0d_no_coin", v), cv_lat, 0);
      if (v == 0) begin
        exp_q = '{0, 0, 1, 2, 3, 3, 3};
        seq_chk("v0_seq", fx);
        chk("v0_cv_latency", cv_lat, 2);
      end
      if (v == 2) chk("zero_done_latency", lat, 2);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", v), int'(chg_done), 0);
      chk($sformatf("v%0d_hold_short", v), int'(chg_short), vecs[v].short_e);
    end

    // Jam: hopper refuses 25-coins, so the 40 is paid with four 10-coins.
    run_txn(7'd40, 4'b0000, 10'h2AA, 2, lat, cv_lat, hi0, fx);
    chk("jam_short", int'(chg_short), 0);
    chk("jam_count", int'(coin_count), 4);
    chk("jam_hold_cycles", hi0, 16);
    exp_q = '{1, 1, 1, 1};
    seq_chk("jam_seq", fx);

    // Request during ISSUE is dropped; original transaction completes.
    @(negedge clk);
    fx = xfer_n;
    coin_empty = 4'b0000;
    coin_ready = 1'b0;
    dispense_valid = 1'b1;
    currency_change = 7'd30;
    item_dispensed = 10'h155;
    @(negedge clk);
    dispense_valid = 1'b0;
    n = 0;
    while (!coin_valid && n < 20) begin @(negedge clk); n++; end
    chk("drop_reach_issue", int'(coin_valid), 1);
    dispense_valid = 1'b1;
    currency_change = 7'd5;
    item_dispensed = 10'h0F0;
    @(negedge clk);
    dispense_valid = 1'b0;
    chk("drop_pulse", int'(req_drop), 1);
    @(negedge clk);
    chk("drop_pulse_end", int'(req_drop), 0);
    coin_ready = 1'b1;
    n = 0;
    while (!chg_done && n < 100) begin @(negedge clk); n++; end
    chk("drop_done", int'(chg_done), 1);
    chk("drop_short", int'(chg_short), 0);
    chk("drop_count", int'(coin_count), 2);
    chk("drop_item", int'(chg_item), 'h155);
    exp_q = '{0, 2};
    seq_chk("drop_seq", fx);

    // Reset during ISSUE abandons the transaction silently.
    @(negedge clk);
    coin_ready = 1'b0;
    dispense_valid = 1'b1;
    currency_change = 7'd30;
    @(negedge clk);
    dispense_valid = 1'b0;
    n = 0;
    while (!coin_valid && n < 20) begin @(negedge clk); n++; end
    chk("rst_reach_issue", int'(coin_valid), 1);
    d0 = done_cnt;
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_coin_valid", int'(coin_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", done_cnt, d0);
    chk("midrst_idle", int'(busy), 0);

    // Randomized transactions against the greedy model.
    for (int t = 0; t < 40; t++) begin
      logic [6:0] a;
      logic [3:0] e;
      logic [9:0] g;
      a = 7'($urandom_range(0, 127));
      e = 4'($urandom_range(0, 15));
      g = 10'($urandom_range(0, 1023));
      model(int'(a), e, sm, cm);
      run_txn(a, e, g, 1, lat, cv_lat, hi0, fx);
      chk($sformatf("r%0d_short", t), int'(chg_short), sm);
      chk($sformatf("r%0d_count", t), int'(coin_count), cm);
      chk($sformatf("r%0d_item", t), int'(chg_item), int'(g));
      seq_chk($sformatf("r%0d_seq", t), fx);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
